// File: rtl/fft_pkg.sv
// Shared sizing, latency and state types for the
// radix-2 FFT stage sequencer.
package fft_pkg;

  localparam int LOG2N      = 4;
  localparam int N          = 1 << LOG2N;
  localparam int HALF       = N / 2;
  localparam int BF_LATENCY = 3;
  localparam int RD_LATENCY = 1;
  localparam int PIPE       = RD_LATENCY + BF_LATENCY;

  localparam int AW = LOG2N;
  localparam int TW = LOG2N - 1;
  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int PW = $clog2(PIPE);
  localparam int CW = (BW > PW) ? BW : PW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } wr_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly read-address pair and twiddle index
// for a given stage and butterfly number.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [SW-1:0] stage,
  input  logic [BW-1:0] b,
  output logic [AW-1:0] addr_1,
  output logic [AW-1:0] addr_2,
  output logic [TW-1:0] tw_index
);

  logic [AW-1:0] span;
  logic [AW-1:0] grp;
  logic [AW-1:0] pos;
  logic [SW-1:0] tsh;

  always_comb begin
    span     = AW'(1) << stage;
    grp      = {1'b0, b} >> stage;
    pos      = {1'b0, b} & (span - AW'(1));
    // groups are 2*span wide; pos is the offset inside
    addr_1   = ((grp << stage) << 1) | pos;
    addr_2   = addr_1 + span;
    tsh      = SW'(TW) - stage;
    tw_index = TW'(pos << tsh);
  end

endmodule

// File: rtl/fft_stage_controller.sv
// Ping-pong bank sequencer: issues butterfly reads,
// then the matching writes PIPE cycles later.
module fft_stage_controller
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          host_sel,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          select,
  output logic          write_enable,
  output logic [AW-1:0] addr_1,
  output logic [AW-1:0] addr_2,
  output logic [AW-1:0] addw_1,
  output logic [AW-1:0] addw_2,
  output logic          rd_valid,
  output logic [TW-1:0] tw_index
);

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy_q, done_q, sel_q, rdv_q;
  logic [AW-1:0] a1_q, a2_q;
  logic [TW-1:0] tw_q;
  wr_t           pipe_q [PIPE];

  logic          issue_d;
  logic [AW-1:0] gen_a1, gen_a2;
  logic [TW-1:0] gen_tw;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(PIPE - 1)) begin
          cnt_d = '0;
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign issue_d = (state_d == S_ISSUE);

  // addresses are generated for the cycle being entered
  fft_addr_gen u_addr_gen (
    .stage    (stage_d),
    .b        (cnt_d[BW-1:0]),
    .addr_1   (gen_a1),
    .addr_2   (gen_a2),
    .tw_index (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      rdv_q   <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      tw_q    <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_ISSUE) ||
                 (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      rdv_q   <= issue_d;
      if (issue_d) begin
        a1_q <= gen_a1;
        a2_q <= gen_a2;
        tw_q <= gen_tw;
      end
      // bank flips only when a new stage begins
      if (state_d == S_IDLE) begin
        sel_q <= host_sel;
      end else if (state_d != S_DONE) begin
        sel_q <= ~stage_d[0];
      end
      pipe_q[0].we <= rdv_q;
      pipe_q[0].a1 <= a1_q;
      pipe_q[0].a2 <= a2_q;
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign stage        = stage_q;
  assign select       = sel_q;
  assign rd_valid     = rdv_q;
  assign addr_1       = a1_q;
  assign addr_2       = a2_q;
  assign tw_index     = tw_q;
  assign write_enable = pipe_q[PIPE-1].we;
  assign addw_1       = pipe_q[PIPE-1].a1;
  assign addw_2       = pipe_q[PIPE-1].a2;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Self-checking bench for fft_stage_controller against
// a cycle-count model of one transform.
module tb_fft_stage_controller;

  localparam int STAGES = 4;
  localparam int HALF   = 8;
  localparam int PIPE   = 4;
  localparam int SLEN   = HALF + PIPE;
  localparam int RUN    = STAGES * SLEN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       host_sel;
  logic       busy, done, select;
  logic       write_enable, rd_valid;
  logic [1:0] stage;
  logic [3:0] addr_1, addr_2, addw_1, addw_2;
  logic [2:0] tw_index;

  int tests = 0;
  int fails = 0;

  int          mc = 0;
  logic        sel_e = 1'b0;
  int          busy_n = 0;
  int          wr_n = 0;
  logic [15:0] seen = '0;

  fft_stage_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .host_sel     (host_sel),
    .busy         (busy),
    .done         (done),
    .stage        (stage),
    .select       (select),
    .write_enable (write_enable),
    .addr_1       (addr_1),
    .addr_2       (addr_2),
    .addw_1       (addw_1),
    .addw_2       (addw_2),
    .rd_valid     (rd_valid),
    .tw_index     (tw_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t mc=%0d)",
               nm, act, exp, $time, mc);
    end
  endtask

  // butterfly b of stage s: plain index arithmetic
  function automatic void bf(input int s, input int b,
                             output int a1, output int a2,
                             output int tw);
    int span;
    span = 2 ** s;
    a1 = (b / span) * 2 * span + (b % span);
    a2 = a1 + span;
    tw = (b % span) * (HALF / span);
  endfunction

  task automatic check_cycle();
    int   k, r, e1, e2, et;
    logic busy_e, done_e, rd_e, we_e, s_e;
    busy_e = 0; done_e = 0; rd_e = 0; we_e = 0;
    s_e = sel_e; k = 0; r = 0;
    if (mc >= 1 && mc <= RUN) begin
      k = (mc - 1) / SLEN;
      r = (mc - 1) % SLEN;
      busy_e = 1;
      rd_e = (r < HALF);
      we_e = (r >= PIPE);
      s_e = (k % 2 == 0);
    end else if (mc == RUN + 1) begin
      k = STAGES - 1;
      done_e = 1;
      s_e = (k % 2 == 0);
    end
    chk("busy", busy, busy_e);
    chk("done", done, done_e);
    chk("rd_valid", rd_valid, rd_e);
    chk("write_enable", write_enable, we_e);
    chk("select", select, s_e);
    if (mc != 0) chk("stage", stage, k);
    if (rd_e) begin
      bf(k, r, e1, e2, et);
      chk("addr_1", addr_1, e1);
      chk("addr_2", addr_2, e2);
      chk("tw_index", tw_index, et);
    end
    if (we_e) begin
      bf(k, r - PIPE, e1, e2, et);
      chk("addw_1", addw_1, e1);
      chk("addw_2", addw_2, e2);
    end
    if (busy) busy_n++;
    if (write_enable) begin
      wr_n++;
      seen[addw_1] = 1'b1;
      seen[addw_2] = 1'b1;
    end
    if (we_e && r == SLEN - 1) begin
      chk("stage_perm", seen, 16'hFFFF);
      seen = '0;
    end
    if (mc == 6) begin
      chk("s0b5_addr_1", addr_1, 10);
      chk("s0b5_addr_2", addr_2, 11);
      chk("s0b5_tw", tw_index, 0);
      chk("s0b5_select", select, 1);
    end
    if (mc == 10) begin
      chk("s0b5_addw_1", addw_1, 10);
      chk("s0b5_addw_2", addw_2, 11);
      chk("s0b5_we", write_enable, 1);
    end
    if (mc == 16) begin
      chk("s1b3_addr_1", addr_1, 5);
      chk("s1b3_addr_2", addr_2, 7);
      chk("s1b3_tw", tw_index, 4);
      chk("s1b3_select", select, 0);
    end
    if (mc == 42) begin
      chk("s3b5_addr_1", addr_1, 5);
      chk("s3b5_addr_2", addr_2, 13);
      chk("s3b5_tw", tw_index, 5);
    end
    if (mc == RUN + 1) begin
      chk("done_pulse", done, 1);
      chk("busy_cycles", busy_n, 48);
      chk("write_count", wr_n, 32);
      busy_n = 0;
      wr_n = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mc = 0; sel_e = 0;
        busy_n = 0; wr_n = 0; seen = '0;
      end else begin
        if (mc == 0) begin
          if (start) mc = 1;
        end else if (mc == RUN + 1) begin
          mc = 0;
        end else begin
          mc++;
        end
        if (mc == 0) sel_e = host_sel;
      end
      #1;
      check_cycle();
    end
  end

  task automatic wait_mc(input int target, input int budget);
    int n = 0;
    while (mc != target && n < budget) begin
      @(negedge clk);
      host_sel = 1'($urandom_range(0, 1));
      n++;
    end
    chk("wait_timeout", mc, target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_sel"}, select, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_addr"}, {addr_1, addr_2}, 0);
    chk({tag, "_addw"}, {addw_1, addw_2}, 0);
    chk({tag, "_tw"}, tw_index, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    host_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    host_sel = 1'b1;
    repeat (3) @(negedge clk);
    host_sel = 1'b0;
    @(negedge clk);

    // run with stray starts in stage 2 and at DONE exit
    pulse_start();
    wait_mc(30, 60);
    pulse_start();
    wait_mc(RUN + 1, 60);
    pulse_start();
    chk("done_exit_ignored", mc, 0);
    repeat (3) @(negedge clk);

    // second run, aborted by reset
    pulse_start();
    wait_mc(20, 40);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean run after abort
    pulse_start();
    wait_mc(RUN + 1, 60);
    @(negedge clk);

    repeat (200) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      host_sel = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    wait_mc(0, 80);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
